// File: rtl/sram_image_pkg.sv
// Shared types for the packed-pixel SRAM image store.
// Holds the controller state encoding and the default SRAM word width.
package sram_image_pkg;

  localparam int WORD_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RSP,
    RMW_RD,
    RMW_WR,
    CLEAR
  } state_t;

endpackage

// File: rtl/sram_model.sv
// Single-port SRAM model.
//   clk   : write/read clock (rising edge)
//   ren   : read enable; with RAM_IS_SYNCHRONOUS=1 rdat updates at the edge
//   wen   : write enable, writes wdat to addr at the edge
//   addr  : word address
//   wdat  : write word
//   rdat  : read word (registered, or combinational when not synchronous)
// Contents have no reset.
module sram_model #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 4,
  parameter int DEPTH              = 1 << ADDR_WIDTH,
  parameter bit RAM_IS_SYNCHRONOUS = 1'b1
) (
  input  logic                  clk,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[addr] <= wdat;
  end

  if (RAM_IS_SYNCHRONOUS) begin : g_sync
    always_ff @(posedge clk) begin
      if (ren) rdat <= mem[addr];
    end
  end else begin : g_async
    assign rdat = mem[addr];
  end

endmodule

// File: rtl/sram_image_packed.sv
// Pixel-addressed image store packing PPW pixels per SRAM word.
//   ramclk/rst        : clock, asynchronous active-high reset
//   req_valid/ready   : pixel request handshake
//   req_write         : 1 = write wdat, 0 = read
//   x_addr, y_addr    : pixel column / row
//   wdat              : write pixel
//   rsp_valid, rdat   : read response pulse, read pixel (held)
//   clr_start         : zero-fill the whole image
//   clr_done          : one-cycle pulse after the last word is cleared
// Reads take RD -> RSP; writes are read-modify-write (RMW_RD -> RMW_WR).
module sram_image_packed
  import sram_image_pkg::*;
#(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 64,
  parameter int Y_MAX       = 48,
  parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
  parameter logic [PIXEL_DEPTH-1:0] BORDER_VAL = '0,
  localparam int XW = $clog2(X_MAX) + 1,
  localparam int YW = $clog2(Y_MAX) + 1
) (
  input  logic                   ramclk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [XW-1:0]          x_addr,
  input  logic [YW-1:0]          y_addr,
  input  logic [PIXEL_DEPTH-1:0] wdat,
  output logic                   rsp_valid,
  output logic [PIXEL_DEPTH-1:0] rdat,
  input  logic                   clr_start,
  output logic                   clr_done
);

  localparam int PPW     = WORD_WIDTH / PIXEL_DEPTH;
  localparam int N_WORDS = (X_MAX * Y_MAX + PPW - 1) / PPW;
  localparam int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int LW      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(N_WORDS - 1);

  if (WORD_WIDTH % PIXEL_DEPTH != 0) begin : g_bad_cfg
    $error("WORD_WIDTH must be a multiple of PIXEL_DEPTH");
  end

  state_t state, state_nxt;

  logic [AW-1:0]          word_q, cnt;
  logic [LW-1:0]          lane_q;
  logic                   oob_q;
  logic [PIXEL_DEPTH-1:0] wdat_q;

  logic                   ren, wen;
  logic [AW-1:0]          addr;
  logic [WORD_WIDTH-1:0]  sram_wdat, sram_rdat, merged;
  logic [PIXEL_DEPTH-1:0] lane_pix;

  int   lin;
  logic oob;

  assign oob       = (int'(x_addr) >= X_MAX) || (int'(y_addr) >= Y_MAX);
  assign lin       = int'(y_addr) * X_MAX + int'(x_addr);
  // clear has priority over a simultaneous request
  assign req_ready = (state == IDLE) && !clr_start;
  assign lane_pix  = sram_rdat[lane_q*PIXEL_DEPTH +: PIXEL_DEPTH];

  // replace only the target lane of the word read back in RMW_RD
  always_comb begin
    merged = sram_rdat;
    merged[lane_q*PIXEL_DEPTH +: PIXEL_DEPTH] = wdat_q;
  end

  always_ff @(posedge ramclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = word_q;
    sram_wdat = merged;
    case (state)
      IDLE: begin
        if (clr_start)
          state_nxt = CLEAR;
        else if (req_valid && !req_write)
          state_nxt = RD;                 // out-of-bounds reads keep read latency
        else if (req_valid && !oob)
          state_nxt = RMW_RD;             // out-of-bounds writes are dropped here
      end
      RD: begin
        ren       = !oob_q;
        state_nxt = RSP;
      end
      RSP:    state_nxt = IDLE;
      RMW_RD: begin
        ren       = 1'b1;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        wen       = 1'b1;
        state_nxt = IDLE;
      end
      CLEAR: begin
        wen       = 1'b1;
        addr      = cnt;
        sram_wdat = '0;
        if (cnt == LAST_WORD) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ramclk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      clr_done  <= 1'b0;
      rdat      <= '0;
      word_q    <= '0;
      lane_q    <= '0;
      oob_q     <= 1'b0;
      wdat_q    <= '0;
    end else begin
      rsp_valid <= (state == RSP);
      clr_done  <= (state == CLEAR) && (cnt == LAST_WORD);
      cnt       <= (state == CLEAR && cnt != LAST_WORD) ? cnt + 1'b1 : '0;
      if (state == IDLE && req_valid && req_ready) begin
        word_q <= AW'(lin / PPW);
        lane_q <= LW'(lin % PPW);
        oob_q  <= oob;
        wdat_q <= wdat;
      end
      if (state == RSP) rdat <= oob_q ? BORDER_VAL : lane_pix;
    end
  end

  sram_model #(
    .DATA_WIDTH        (WORD_WIDTH),
    .ADDR_WIDTH        (AW),
    .DEPTH             (N_WORDS),
    .RAM_IS_SYNCHRONOUS(1'b1)
  ) u_sram (
    .clk (ramclk),
    .ren (ren),
    .wen (wen),
    .addr(addr),
    .wdat(sram_wdat),
    .rdat(sram_rdat)
  );

endmodule
